// File: rtl/mu0_pkg.sv
// Shared types and default constants for the MU0 run controller.
package mu0_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RST  = 3'd1,
      RUN  = 3'd2,
      HALT = 3'd3,
      TOUT = 3'd4
   } run_state_t;

   localparam int MU0_RESET_CYCLES   = 2;
   localparam int MU0_TIMEOUT_CYCLES = 1000;

endpackage

// File: rtl/mu0_sat_counter.sv
// Unsigned up-counter that sticks at all-ones instead of wrapping.
module mu0_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);

   localparam logic [CNT_W-1:0] MAX_VAL = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (inc && (r_q != MAX_VAL)) begin
         r_q <= r_q + 1'b1;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/mu0_run_ctrl.sv
// Run sequencer for the MU0 core: holds core reset, runs until halt or
// timeout, and counts run cycles, memory reads and memory writes.
//
// state | meaning
// IDLE  | waiting for Start, core held in reset
// RST   | core reset held for RESET_CYCLES cycles
// RUN   | core running, counters active
// HALT  | core halted itself, core state left visible
// TOUT  | run exceeded TIMEOUT_CYCLES, core forced back into reset
module mu0_run_ctrl
   import mu0_pkg::*;
#(
   parameter int RESET_CYCLES   = MU0_RESET_CYCLES,
   parameter int TIMEOUT_CYCLES = MU0_TIMEOUT_CYCLES,
   parameter int CNT_W          = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Halted,
   input  logic             Rd,
   input  logic             Wr,
   output logic             Cpu_reset,
   output logic             Running,
   output logic             Done,
   output logic             Timeout,
   output logic [CNT_W-1:0] Cycle_count,
   output logic [CNT_W-1:0] Rd_count,
   output logic [CNT_W-1:0] Wr_count
);

   localparam int               RCW      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [RCW-1:0]   RST_LOAD = RCW'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   run_state_t       r_state;
   run_state_t       w_state_nxt;
   logic [RCW-1:0]   r_rst_cnt;
   logic             w_load;
   logic             w_in_run;
   logic             r_cpu_reset;
   logic             r_running;
   logic             r_done;
   logic             r_timeout;
   logic [CNT_W-1:0] w_cycle_count;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         IDLE: begin
            if (Start) begin
               w_state_nxt = RST;
               w_load      = 1'b1;
            end
         end
         RST: begin
            if (r_rst_cnt == '0) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            // Halt wins over a timeout landing on the same cycle.
            if (Halted) begin
               w_state_nxt = HALT;
            end else if (w_cycle_count == TO_LAST) begin
               w_state_nxt = TOUT;
            end
         end
         HALT, TOUT: begin
            if (Start) begin
               w_state_nxt = RST;
               w_load      = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_rst_cnt <= '0;
      end else if (w_load) begin
         r_rst_cnt <= RST_LOAD;
      end else if ((r_state == RST) && (r_rst_cnt != '0)) begin
         r_rst_cnt <= r_rst_cnt - 1'b1;
      end
   end

   // Outputs are flopped from the next state so they line up with r_state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_cpu_reset <= 1'b1;
         r_running   <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_cpu_reset <= (w_state_nxt != RUN) && (w_state_nxt != HALT);
         r_running   <= (w_state_nxt == RUN);
         r_done      <= (w_state_nxt == HALT) || (w_state_nxt == TOUT);
         r_timeout   <= (w_state_nxt == TOUT);
      end
   end

   assign w_in_run = (r_state == RUN);

   mu0_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
      .clk (Clk),
      .rst (Reset),
      .clr (w_load),
      .inc (w_in_run),
      .q   (w_cycle_count)
   );

   mu0_sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
      .clk (Clk),
      .rst (Reset),
      .clr (w_load),
      .inc (w_in_run && Rd),
      .q   (Rd_count)
   );

   mu0_sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
      .clk (Clk),
      .rst (Reset),
      .clr (w_load),
      .inc (w_in_run && Wr),
      .q   (Wr_count)
   );

   assign Cycle_count = w_cycle_count;
   assign Cpu_reset   = r_cpu_reset;
   assign Running     = r_running;
   assign Done        = r_done;
   assign Timeout     = r_timeout;

endmodule

// File: doc/mu0_run_ctrl.md
# mu0_run_ctrl

Run controller for MU0 simulation and FPGA bring-up. It replaces hand-timed reset pulses and fixed end-of-run delays with a parametrised sequencer. It drives the core's reset, watches `Halted`, enforces a cycle timeout, and counts cycles, memory reads and memory writes. It sits between the board/bench clock and reset and the `mu0` core/`mu0_memory` pair. Benches and hardware poll `Done`/`Timeout` and the counters.

## Interface
Parameters:
- `RESET_CYCLES`, default 2: cycles `Cpu_reset` is held high after `Start`; must be ≥ 1.
- `TIMEOUT_CYCLES`, default 1000: run cycles before timeout; must satisfy 1 ≤ value ≤ 2^`CNT_W`−1.
- `CNT_W`, default 16: width of all counters.

Ports:
- `Clk` in 1: single clock; everything is on the rising edge.
- `Reset` in 1: asynchronous, active-high reset of this block.
- `Start` in 1: level-sampled request to begin a run.
- `Halted` in 1: from the `mu0` core.
- `Rd` in 1: from the `mu0` core.
- `Wr` in 1: from the `mu0` core.
- `Cpu_reset` out 1: reset to the `mu0` core.
- `Running` out 1: high in RUN.
- `Done` out 1: run finished, whether halted or timed out.
- `Timeout` out 1: run ended by timeout.
- `Cycle_count` out `CNT_W`: cycles spent in RUN.
- `Rd_count` out `CNT_W`: RUN cycles with `Rd` high.
- `Wr_count` out `CNT_W`: RUN cycles with `Wr` high.

## Operation
States are IDLE, RST, RUN, HALT, TOUT.
- **`Reset` asserted:**
  - State becomes IDLE.
  - `Cpu_reset`=1; `Running`=`Done`=`Timeout`=0.
  - All counters are 0.
- **IDLE:**
  - `Cpu_reset`=1.
  - `Start`=1 → RST: load the reset counter with `RESET_CYCLES`−1 and clear all three counters.
- **RST:**
  - `Cpu_reset`=1.
  - Decrement the reset counter each cycle; at 0 → RUN.
  - `Halted`, `Rd`, `Wr` and `Start` are ignored.
- **RUN:**
  - `Cpu_reset`=0, `Running`=1.
  - Every cycle: `Cycle_count`+1. `Rd`=1 → `Rd_count`+1. `Wr`=1 → `Wr_count`+1. Both can increment in the same cycle.
  - `Halted`=1 → HALT. The cycle in which `Halted` is sampled is counted.
  - Otherwise, `Cycle_count`==`TIMEOUT_CYCLES`−1 → TOUT, with `Cycle_count` ending at `TIMEOUT_CYCLES`.
  - `Halted` and timeout in the same cycle → HALT; halt has priority.
  - `Start` is ignored.
- **HALT:**
  - `Done`=1, `Timeout`=0, `Cpu_reset`=0 (core state stays observable).
  - Counters are frozen.
- **TOUT:**
  - `Done`=1, `Timeout`=1, `Cpu_reset`=1 (stops a runaway core).
  - Counters are frozen.
- **HALT/TOUT + `Start`=1:** → RST with the same reload and counter clear as IDLE. `Done`/`Timeout` drop on that edge.
- **Counters:**
  - All saturate at 2^`CNT_W`−1; they never wrap.
  - Unsigned, `CNT_W` bits.
- **`Reset` mid-run:** every output returns to its reset value immediately and asynchronously, with no partial state retained.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- **Start to run:** `Start` sampled at edge E0 → `Running`=1 and `Cpu_reset`=0 after edge E0+`RESET_CYCLES`. `Cpu_reset` stays high for exactly `RESET_CYCLES` cycles after E0.
- **Halt:** `Halted` sampled at edge Eh → `Done`=1 after Eh; `Running` falls on the same edge.
- **Timeout:** a run with no halt spends exactly `TIMEOUT_CYCLES` cycles in RUN.
- **`Start` held high:** has no effect in RST and RUN. Held through HALT or TOUT, it causes a restart one cycle after entry.

## Structure
- Shared package `mu0_pkg` holds:
  - the state enum `run_state_t` (IDLE, RST, RUN, HALT, TOUT);
  - the default parameter constants `MU0_RESET_CYCLES` and `MU0_TIMEOUT_CYCLES`.
- One sub-module, `mu0_sat_counter` (`CNT_W`, with `clr`, `inc` and `q`), is instantiated three times for `Cycle_count`, `Rd_count` and `Wr_count`.
- The FSM and reset counter live in the top module.

## Test plan
Parameters for all scenarios: `RESET_CYCLES`=2, `TIMEOUT_CYCLES`=40, `CNT_W`=8.
- **Power-on:** `Reset` pulse → `Cpu_reset`=1, `Done`=0, all counters 0. Asserting `Halted` in IDLE changes nothing.
- **Normal halt:**
  - Stimulus: `Start` for one cycle; `Halted` on the 10th RUN cycle; `Rd` high in 6 of those cycles and `Wr` in 2, one cycle having both.
  - Response: `Cpu_reset` high for 2 cycles after `Start`. Then `Done`=1, `Timeout`=0, `Cycle_count`=10, `Rd_count`=6, `Wr_count`=2, `Cpu_reset`=0.
- **Timeout:** `Halted` never asserted → after 40 RUN cycles `Timeout`=1, `Done`=1, `Cycle_count`=40, `Cpu_reset`=1.
- **Simultaneous:** `Halted` rises on RUN cycle 40 → HALT, `Timeout`=0, `Cycle_count`=40.
- **Restart and saturation:**
  - `Start` in HALT → counters clear and the reset sequence repeats.
  - Rebuild with `TIMEOUT_CYCLES`=255 and `Rd` held high → `Rd_count` stops at 255.
- **Reset mid-run:** `Reset` asserted between clock edges in RUN cycle 5 → `Cpu_reset`=1 and counters 0 before the next edge; state IDLE.
